iter_multiplier: RTL
====================

# iter_multiplier

Parametrised multi-cycle signed/unsigned multiplier for the EX stage, replacing the single-cycle combinational multiply with an iterative shift-add datapath that retires BITS_PER_CYCLE multiplier bits per clock. It accepts one operation at a time through a start/busy/done handshake and returns a full double-width product (HI:LO) to the HI/LO write-back path. A cancel input lets the pipeline abandon an in-flight multiply on flush or exception.

## Interface
- WIDTH, 32: operand width in bits; must be divisible by BITS_PER_CYCLE.
- BITS_PER_CYCLE, 2: multiplier bits retired per iteration; legal values 1, 2, 4. Any other value is an elaboration error.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- cancel  in  1  abort the in-flight operation; has priority over start.
- signed_op  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- operand_1  in  WIDTH  multiplicand; sampled with start.
- operand_2  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse; result valid.
- result  out  2*WIDTH  product, {HI, LO}; held until the next completed operation.

## Operation
- N = WIDTH / BITS_PER_CYCLE iterations.
- States:
  - IDLE: wait for start.
  - CALC: iterate.
  - DONE: done=1 for one cycle.
- Accept (start=1 and cancel=0 in IDLE or DONE):
  - Capture mag1 = |operand_1| and mag2 = |operand_2|. Magnitude is the two's complement negation when signed_op=1 and MSB=1, else the raw value.
  - Capture neg = signed_op & (operand_1[MSB] ^ operand_2[MSB]).
  - Clear the accumulator and the iteration counter. Go to CALC.
- CALC, each cycle:
  - Add mag1 × (low BITS_PER_CYCLE bits of the remaining multiplier) into a 2*WIDTH-bit accumulator at the current shift position.
  - Shift the multiplier right by BITS_PER_CYCLE. Increment the counter.
  - On the N-th iteration, write result = neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits, and go to DONE.
- DONE → IDLE next cycle. If start=1 in DONE, accept it and go directly to CALC; done is still high in that DONE cycle.
- start in CALC is ignored; there is no queueing.
- Arithmetic:
  - Magnitudes are unsigned WIDTH-bit values. The most-negative operand has magnitude 2^(WIDTH-1), which fits.
  - The product magnitude always fits in 2*WIDTH bits.
  - Zero product with neg=1 yields 0, not -0.
- cancel:
  - In CALC: go to IDLE next cycle, no done pulse, result unchanged.
  - In IDLE or DONE: blocks a simultaneous start. In DONE, done is still high that cycle, since the result is already committed.
- result changes only on the final CALC iteration.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, accumulator/counter/neg=0. Reset mid-CALC discards the operation.
- Accept at clock edge T:
  - busy=1 during cycles T+1 … T+N.
  - done=1 and result valid in cycle T+N+1.
  - Latency is N+1 cycles from accept to done.
- Back-to-back: a start in the DONE cycle is accepted at that edge. Throughput is one product per N+1 cycles.
- busy and done are never high in the same cycle.
- Outputs are registered. There are no combinational paths from inputs to busy, done or result.

## Test plan
- Reset:
  - Assert rst_n=0 asynchronously mid-CALC, with operands 0x12345678 × 0x9ABCDEF0.
  - busy, done and result go to 0 immediately, with no clock needed.
  - After release, no done pulse appears.
- Unsigned, WIDTH=32, BITS_PER_CYCLE=2:
  - Apply 0xFFFFFFFF × 0xFFFFFFFF with signed_op=0.
  - done arrives exactly 17 cycles after the accept edge, with result=0xFFFFFFFE_00000001.
  - busy is high for exactly 16 cycles.
- Signed corners:
  - -1 × 1 (0xFFFFFFFF × 0x00000001) → 0xFFFFFFFF_FFFFFFFF.
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - 0x80000000 × 0 → 0.
  - 7 × -3 → 0xFFFFFFFF_FFFFFFEB.
- Handshake:
  - Issue start again during CALC: it is ignored, and the first product completes with the original operands.
  - Issue start during DONE: the second operation is accepted, and done pulses again 17 cycles later.
  - result holds the first product until the second done.
- Cancel:
  - Assert cancel in the 5th CALC cycle: busy drops next cycle, no done pulse, result keeps its previous value.
  - Assert start and cancel together in IDLE: no operation starts.
- Parameter sweep:
  - Sweep BITS_PER_CYCLE ∈ {1,2,4} and WIDTH ∈ {8,16,32} with 10k random signed/unsigned pairs against a reference model.
  - Latency is WIDTH/BITS_PER_CYCLE + 1 in every configuration.

Source files
------------

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock
// on operand magnitudes, then applies the product sign once on the final iteration.
module iter_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cancel,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
      $error("iter_multiplier: BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_width
      $error("iter_multiplier: WIDTH must be divisible by BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;   // multiplicand magnitude, pre-shifted to the current digit position
  logic [WIDTH-1:0]   mplr_q,  mplr_d;
  logic [PW-1:0]      acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               neg_q,   neg_d;
  logic [PW-1:0]      result_q, result_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [PW-1:0]      digit, partial, acc_sum;
  logic               last_iter;

  assign mag1 = (signed_op && operand_1[WIDTH-1]) ? (~operand_1 + WIDTH'(1)) : operand_1;
  assign mag2 = (signed_op && operand_2[WIDTH-1]) ? (~operand_2 + WIDTH'(1)) : operand_2;

  assign digit     = PW'(mplr_q[BITS_PER_CYCLE-1:0]);
  assign partial   = mcand_q * digit;
  assign acc_sum   = acc_q + partial;
  assign last_iter = (cnt_q == CNT_W'(N - 1));

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !cancel) begin
          mcand_d = PW'(mag1);
          mplr_d  = mag2;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = signed_op & (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_sum;
          mcand_d = mcand_q << BITS_PER_CYCLE;
          mplr_d  = mplr_q >> BITS_PER_CYCLE;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_iter) begin
            // Negating a zero magnitude yields zero, so no -0 special case is needed.
            result_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs decode the state register only; no input reaches them combinationally.
  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
